y_buf_argmax_reader: RTL
========================

// Module: y_buf_argmax_reader
// PURPOSE
//  Reader on the far end of the result (Y) buffer. After inference completes, it reads back the
//  10 signed 32-bit layer-5 scores per image, one per cycle, from the 32-bit-word, byte-addressed Y buffer.
//  For each image it takes the argmax as the predicted class and compares it with a label ROM.
//  Per-image results go out on a valid/ready stream; a running correct-prediction count is kept.
// PARAMETERS
//  IN_IMG_NUM      10   images per run
//  Y_BUF_ADDR_WIDTH 32  Y buffer byte address width
//  Y_BUF_DATA_WIDTH 32  Y buffer data width (signed score)
//  RD_LAT          1    Y buffer / label ROM read latency, cycles (1..3)
// PORTS
//  clk_i         in   1    clock
//  rst_i         in   1    synchronous active-high reset
//  start_i       in   1    one-cycle pulse: begin read-back (e.g. from done_intr_o)
//  y_buf_en_o    out  1    Y buffer read enable
//  y_buf_addr_o  out  Y_BUF_ADDR_WIDTH  byte addr = (img*10+k)*4
//  y_buf_data_i  in   Y_BUF_DATA_WIDTH  signed score, valid RD_LAT cycles after en
//  lbl_en_o      out  1    label ROM read enable
//  lbl_addr_o    out  $clog2(IN_IMG_NUM)  image index
//  lbl_data_i    in   4    true class 0..9, valid RD_LAT cycles after en
//  res_valid_o   out  1    per-image result valid
//  res_ready_i   in   1    consumer ready
//  res_img_o     out  $clog2(IN_IMG_NUM)  image index of result
//  res_class_o   out  4    predicted class
//  res_score_o   out  Y_BUF_DATA_WIDTH  winning score
//  res_hit_o     out  1    res_class_o == label
//  correct_cnt_o out  $clog2(IN_IMG_NUM+1)  hits so far in this run
//  busy_o        out  1    high from start accept to done_o
//  done_o        out  1    one-cycle pulse after last result handshake
// BEHAVIOUR
//  - Reset: every output 0; FSM in IDLE; counters 0. Reset mid-run aborts at once, no done_o.
//  - FSM IDLE->READ on start_i; READ->DRAIN after 10th read; DRAIN->EMIT when 10th score arrives;
//    EMIT->READ (next img) or ->DONE on handshake of last img; DONE->IDLE after 1 cycle (done_o=1).
//  - start_i is ignored while busy_o=1. start_i seen in the DONE cycle is also ignored.
//  - READ: y_buf_en_o=1 for exactly 10 consecutive cycles; k=0..9; addr steps by +4.
//    lbl_en_o=1 only with k=0.
//  - Timing: start sampled at cycle 0. Reads are issued at cycles 1..10.
//    res_valid_o rises at cycle 11+RD_LAT, i.e. cycle 12 at RD_LAT=1.
//  - Throughput with res_ready_i held 1: one image per 11+RD_LAT cycles. The next READ starts the
//    cycle after the handshake.
//  - Argmax: signed compare. Strict greater-than replaces the current best, so ties keep the LOWEST
//    class index. Score k=0 initialises the best value; there is no fixed "minimum" seed, so
//    0x8000_0000 scores resolve correctly.
//  - Label: captured RD_LAT cycles after lbl_en_o. res_hit_o is registered together with res_class_o.
//  - Handshake: in EMIT, res_valid_o and all res_* stay stable until res_valid_o&res_ready_i.
//    No reads are issued while stalled. res_valid_o drops the cycle after the handshake.
//    correct_cnt_o += res_hit_o on the handshake cycle.
//  - correct_cnt_o: cleared on start accept; holds its final value in IDLE until the next start.
//  - Last image: the handshake on img IN_IMG_NUM-1 enters DONE. done_o pulses the following cycle;
//    busy_o falls in that same cycle.
//  - Width: the address is computed in Y_BUF_ADDR_WIDTH bits. Maximum address is
//    (10*IN_IMG_NUM-1)*4 = 396 at defaults; no wrap.
// STRUCTURE
//  - Shared package mnist_pkg holds:
//    - NUM_CLASS=10, Y_ADDR_STRIDE=4, CLASS_W=4
//    - FSM state typedef {IDLE,READ,DRAIN,EMIT,DONE}
//  - Sub-module argmax_unit (registered best value/index, clr/valid/data in). It is reused by any
//    later on-chip classifier.
//  - RD_LAT is handled by a valid/index shift register aligned to y_buf_data_i.
// TESTING
//  1. Reset: all outputs 0. start_i at IN_IMG_NUM=10, RD_LAT=1, ready=1 -> addr 0,4..36 at cycles 1..10;
//     first res_valid at cycle 12.
//  2. Scores img0 = {-5,3,9,9,0,...}, label 2 -> class 2 (tie low index), score 9, hit 1.
//     Label 3 -> hit 0.
//  3. All ten scores 0x8000_0000 -> class 0, score 0x8000_0000.
//  4. res_ready_i held 0 for 20 cycles at img3 -> res_* stable, y_buf_en_o=0.
//     Release -> img4 reads start the next cycle.
//  5. Full run, labels match 7 of 10 -> correct_cnt_o=7; one done_o pulse; final addr 396.
//     start_i during the run is ignored.
//  6. rst_i asserted mid-READ of img5 -> outputs 0, IDLE, no done_o. A new start_i then re-runs
//     from addr 0.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants and FSM state type for the MNIST result read-back path.
package mnist_pkg;

    localparam int NUM_CLASS     = 10;
    localparam int Y_ADDR_STRIDE = 4;
    localparam int CLASS_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/argmax_unit.sv
// Running signed argmax over a stream of indexed scores; the first sample after clr seeds the best.
module argmax_unit
    import mnist_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     valid_i,
    input  logic [CLASS_W-1:0]       idx_i,
    input  logic signed [DATA_W-1:0] data_i,
    output logic signed [DATA_W-1:0] best_val_o,
    output logic [CLASS_W-1:0]       best_idx_o,
    output logic [CLASS_W-1:0]       nxt_idx_o
);

    logic                     r_empty;
    logic signed [DATA_W-1:0] r_best_val;
    logic [CLASS_W-1:0]       r_best_idx;
    logic                     w_take;

    // Strict greater-than keeps the lowest index on ties; no sentinel seed is needed.
    assign w_take    = valid_i && (r_empty || (data_i > r_best_val));
    assign nxt_idx_o = w_take ? idx_i : r_best_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_empty    <= 1'b1;
            r_best_val <= '0;
            r_best_idx <= '0;
        end else if (w_take) begin
            r_empty    <= 1'b0;
            r_best_val <= data_i;
            r_best_idx <= idx_i;
        end
    end

    assign best_val_o = r_best_val;
    assign best_idx_o = r_best_idx;

endmodule

// File: rtl/y_buf_argmax_reader.sv
// Reads back per-image class scores from the Y buffer, picks the argmax, checks it against a label ROM.
module y_buf_argmax_reader
    import mnist_pkg::*;
#(
    parameter int  IN_IMG_NUM       = 10,
    parameter int  Y_BUF_ADDR_WIDTH = 32,
    parameter int  Y_BUF_DATA_WIDTH = 32,
    parameter int  RD_LAT           = 1,
    localparam int IMG_W            = $clog2(IN_IMG_NUM),
    localparam int CNT_W            = $clog2(IN_IMG_NUM + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    output logic                        y_buf_en_o,
    output logic [Y_BUF_ADDR_WIDTH-1:0] y_buf_addr_o,
    input  logic [Y_BUF_DATA_WIDTH-1:0] y_buf_data_i,
    output logic                        lbl_en_o,
    output logic [IMG_W-1:0]            lbl_addr_o,
    input  logic [CLASS_W-1:0]          lbl_data_i,
    // Result stream: res_* are held stable while res_valid_o=1 and transfer on res_valid_o & res_ready_i.
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [IMG_W-1:0]            res_img_o,
    output logic [CLASS_W-1:0]          res_class_o,
    output logic [Y_BUF_DATA_WIDTH-1:0] res_score_o,
    output logic                        res_hit_o,
    output logic [CNT_W-1:0]            correct_cnt_o,
    output logic                        busy_o,
    output logic                        done_o,
    output state_t                      dbg_state_o
);

    state_t                      r_state, w_next;
    logic [IMG_W-1:0]            r_img;
    logic [CLASS_W-1:0]          r_k;
    logic [CNT_W-1:0]            r_cnt;
    logic [CLASS_W-1:0]          r_label;
    logic                        r_hit;
    logic [RD_LAT-1:0]           r_vld_pipe;
    logic [CLASS_W-1:0]          r_k_pipe [RD_LAT];

    logic                        w_en, w_start, w_hs, w_last_k, w_last_img;
    logic                        w_arr_vld, w_last_arr;
    logic [CLASS_W-1:0]          w_arr_k, w_nxt_idx, w_best_idx;
    logic [Y_BUF_ADDR_WIDTH-1:0] w_word_idx, w_addr;
    logic [Y_BUF_DATA_WIDTH-1:0] w_best_val;

    assign w_en       = (r_state == READ);
    assign w_start    = (r_state == IDLE) && start_i;
    assign w_hs       = (r_state == EMIT) && res_ready_i;
    assign w_last_k   = (r_k == CLASS_W'(NUM_CLASS - 1));
    assign w_last_img = (r_img == IMG_W'(IN_IMG_NUM - 1));
    assign w_arr_vld  = r_vld_pipe[RD_LAT-1];
    assign w_arr_k    = r_k_pipe[RD_LAT-1];
    assign w_last_arr = w_arr_vld && (w_arr_k == CLASS_W'(NUM_CLASS - 1));

    assign w_word_idx = Y_BUF_ADDR_WIDTH'(r_img) * Y_BUF_ADDR_WIDTH'(NUM_CLASS)
                      + Y_BUF_ADDR_WIDTH'(r_k);
    assign w_addr     = w_word_idx * Y_BUF_ADDR_WIDTH'(Y_ADDR_STRIDE);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        y_buf_en_o   = 1'b0;
        y_buf_addr_o = '0;
        lbl_en_o     = 1'b0;
        lbl_addr_o   = '0;
        res_valid_o  = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        unique case (r_state)
            IDLE: if (start_i) w_next = READ;
            READ: begin
                busy_o       = 1'b1;
                y_buf_en_o   = 1'b1;
                y_buf_addr_o = w_addr;
                if (r_k == '0) begin
                    lbl_en_o   = 1'b1;
                    lbl_addr_o = r_img;
                end
                if (w_last_k) w_next = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (w_last_arr) w_next = EMIT;
            end
            EMIT: begin
                busy_o      = 1'b1;
                res_valid_o = 1'b1;
                if (res_ready_i) w_next = w_last_img ? DONE : READ;
            end
            DONE: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Issue-side valid/index travel alongside the memory latency so they line up with y_buf_data_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) r_k_pipe[i] <= '0;
        end else begin
            r_vld_pipe[0] <= w_en;
            r_k_pipe[0]   <= r_k;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_k_pipe[i]   <= r_k_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_img   <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_label <= '0;
            r_hit   <= 1'b0;
        end else begin
            if (w_start) begin
                r_img <= '0;
                r_k   <= '0;
                r_cnt <= '0;
            end
            if (w_en) r_k <= w_last_k ? '0 : r_k + 1'b1;
            if (w_hs) begin
                r_cnt <= r_cnt + CNT_W'(r_hit);
                if (!w_last_img) r_img <= r_img + 1'b1;
            end
            if (w_arr_vld && (w_arr_k == '0)) r_label <= lbl_data_i;
            // Hit is formed from the argmax's next index so it lands with the final class.
            if (w_last_arr) r_hit <= (w_nxt_idx == r_label);
        end
    end

    argmax_unit #(
        .DATA_W (Y_BUF_DATA_WIDTH)
    ) u_argmax (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (w_start || w_hs),
        .valid_i    (w_arr_vld),
        .idx_i      (w_arr_k),
        .data_i     ($signed(y_buf_data_i)),
        .best_val_o (w_best_val),
        .best_idx_o (w_best_idx),
        .nxt_idx_o  (w_nxt_idx)
    );

    assign res_img_o     = r_img;
    assign res_class_o   = w_best_idx;
    assign res_score_o   = w_best_val;
    assign res_hit_o     = r_hit;
    assign correct_cnt_o = r_cnt;
    assign dbg_state_o   = r_state;

endmodule
